// File: rtl/sm_split32.sv
// Two-stage streaming converter from signed two's-complement to sign + magnitude.
// S1 registers the sign, the conditionally inverted word and the most-negative flag. S2 adds the +1.
module sm_split32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_min
);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q,  s1_sign_d;
    logic [WIDTH-1:0] s1_inv_q,   s1_inv_d;
    logic             s1_min_q,   s1_min_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sign_q,  out_sign_d;
    logic [WIDTH-1:0] out_mag_q,   out_mag_d;
    logic             out_min_q,   out_min_d;
    logic             s2_ready, s1_adv, s2_adv;

    always_comb begin
        s2_ready = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_ready;
        s1_adv   = in_valid && in_ready;
        s2_adv   = s1_valid_q && s2_ready;

        s1_valid_d  = s1_adv || (s1_valid_q && !s2_ready);
        out_valid_d = s2_adv || (out_valid_q && !out_ready);

        // Data registers change only when their stage advances, so held words stay stable.
        s1_sign_d  = s1_sign_q;
        s1_inv_d   = s1_inv_q;
        s1_min_d   = s1_min_q;
        if (s1_adv) begin
            s1_sign_d = in_data[WIDTH-1];
            s1_inv_d  = in_data ^ {WIDTH{in_data[WIDTH-1]}};
            s1_min_d  = (in_data == MIN_VAL);
        end

        out_sign_d = out_sign_q;
        out_mag_d  = out_mag_q;
        out_min_d  = out_min_q;
        if (s2_adv) begin
            out_sign_d = s1_sign_q;
            out_mag_d  = s1_inv_q + {{(WIDTH-1){1'b0}}, s1_sign_q};
            out_min_d  = s1_min_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_inv_q    <= '0;
            s1_min_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_mag_q   <= '0;
            out_min_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_inv_q    <= s1_inv_d;
            s1_min_q    <= s1_min_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_mag_q   <= out_mag_d;
            out_min_q   <= out_min_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_mag   = out_mag_q;
    assign out_min   = out_min_q;
endmodule

// File: tb/tb_sm_split32.sv
// Randomized bench for sm_split32. It uses a queue scoreboard and an arithmetic reference for sign, magnitude and min.
module tb_sm_split32;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [31:0] out_mag;
    logic        out_min;

    sm_split32 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_mag(out_mag), .out_min(out_min)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_lat = 0;
    bit chk_neg = 0;
    int n_in = 0;
    int n_out = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain signed arithmetic on the original word.
    function automatic logic [33:0] model(input logic [31:0] w);
        longint v;
        longint m;
        v = longint'(signed'(w));
        m = (v < 0) ? -v : v;
        return {v < 0, v == -(64'sd1 <<< 31), m[31:0]};
    endfunction

    // Drive one cycle at the negedge, then sample #1 later and score transfers.
    task automatic tick(input logic iv, input logic [31:0] d, input logic ordy, output logic acc);
        logic [31:0] w;
        int c0;
        longint back;
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk("spurious_out", 64'(out_mag), 64'hDEAD);
            else begin
                w = exp_q.pop_front();
                c0 = cyc_q.pop_front();
                chk("result", 64'({out_sign, out_min, out_mag}), 64'(model(w)));
                if (chk_lat) chk("latency", 64'(cyc - c0), 64'd2);
                if (chk_neg) begin
                    back = out_sign ? -longint'(out_mag) : longint'(out_mag);
                    chk("negate_back", 64'(back[31:0]), 64'(w));
                end
            end
        end
        if (acc) begin
            n_in++;
            exp_q.push_back(d);
            cyc_q.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1'b0, 32'h0, 1'b1, a);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic a;
        logic [31:0] basic[6];
        logic [31:0] cur;
        logic        cv;
        logic [33:0] held;
        int acc_cnt, rdy_low, sent, ins, outs;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({out_sign, out_min, out_mag}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // The basic values go in back to back with out_ready high, and latency is checked on each.
        basic[0] = 32'd5;        basic[1] = 32'hFFFFFFFB; basic[2] = 32'd0;
        basic[3] = 32'h7FFFFFFF; basic[4] = 32'h80000000; basic[5] = 32'hFFFFFFFF;
        chk_lat = 1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, basic[i], 1'b1, a);
            chk("basic_accept", 64'(a), 64'd1);
        end
        drain();
        chk_lat = 0;

        // Capacity: with out_ready low, only two words are accepted.
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 32'(i + 100), 1'b0, a);
            if (a) acc_cnt++;
        end
        chk("capacity", 64'(acc_cnt), 64'd2);
        chk("cap_in_ready", 64'(in_ready), 64'd0);
        drain();

        // Backpressure stream 1, -2, 3, -4, ... with out_ready low for cycles 3-7.
        sent = 1;
        for (int c = 0; c < 16; c++) begin
            tick(1'b1, (sent % 2) ? 32'(sent) : 32'(-sent), !(c >= 3 && c <= 7), a);
            if (c == 3) held = {out_sign, out_min, out_mag};
            if (c > 3 && c <= 7) chk("stall_hold", 64'({out_sign, out_min, out_mag}), 64'(held));
            if (c == 7) chk("stall_in_ready", 64'(in_ready), 64'd0);
            if (a) sent++;
        end
        drain();

        // Full-throughput simultaneity.
        tick(1'b1, 32'd11, 1'b0, a);
        tick(1'b1, 32'd12, 1'b0, a);
        ins = n_in; outs = n_out; rdy_low = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 32'(-(i + 13)), 1'b1, a);
            if (!a) rdy_low++;
        end
        chk("thru_in", 64'(n_in - ins), 64'd20);
        chk("thru_out", 64'(n_out - outs), 64'd20);
        chk("thru_ready_low", 64'(rdy_low), 64'd0);
        drain();

        // Reset mid-stream with both stages full.
        tick(1'b1, 32'd21, 1'b0, a);
        tick(1'b1, 32'd22, 1'b0, a);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.delete(); cyc_q.delete();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_outputs", 64'({out_sign, out_min, out_mag}), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        tick(1'b1, 32'hFFFFFFF9, 1'b1, a);
        chk("post_rst_accept", 64'(a), 64'd1);
        drain();

        // Random: the producer holds each word until it is accepted.
        chk_neg = 1;
        sent = 0; cv = 0; cur = '0;
        for (int i = 0; i < 60000 && sent < 10000; i++) begin
            if (!cv) begin
                cv = ($urandom_range(0, 3) != 0);
                cur = $urandom();
                if ($urandom_range(0, 31) == 0) cur = 32'h80000000;
            end
            tick(cv, cur, ($urandom_range(0, 3) != 0), a);
            if (a) begin
                sent++;
                cv = 0;
            end
        end
        chk("rand_sent", 64'(sent), 64'd10000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
